// File: rtl/applyconvolution_udiv_pkg.sv
// ---------------------------------------------------------------------------
// applyConvolution_udiv_pkg
//   Shared types and defaults for the sequential unsigned divider that
//   normalises convolution kernel sums by the kernel weight.
//   - default operand widths (dividend 63, divisor/remainder 32, quotient 31)
//   - FSM state encoding (IDLE, CALC, FIN)
//   - udiv_clog2(): bit count needed for the iteration counter
// ---------------------------------------------------------------------------
package applyConvolution_udiv_pkg;

    localparam int UDIV_DIN0_W = 63;
    localparam int UDIV_DIN1_W = 32;
    localparam int UDIV_DOUT_W = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } udiv_state_e;

    // Width able to count 0 .. value-1; never narrower than one bit.
    function automatic int udiv_clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/applyconvolution_udiv_step.sv
// ---------------------------------------------------------------------------
// applyConvolution_udiv_step
//   One combinational restoring-division iteration.
//   Ports:
//     r_i   [WIDTH-1:0]  partial remainder entering the step (always < div_i)
//     bit_i              next dividend bit, MSB first
//     div_i [WIDTH-1:0]  divisor
//     r_o   [WIDTH-1:0]  partial remainder leaving the step
//     q_o                quotient bit produced by this step
// ---------------------------------------------------------------------------
module applyConvolution_udiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_o
);

    logic [WIDTH:0] r_shift;

    always_comb begin
        r_shift = {r_i, bit_i};
        q_o     = (r_shift >= {1'b0, div_i});
        // Because r_i < div_i, r_shift < 2*div_i and the restored value is
        // always < div_i, so the subtraction can be done modulo 2^WIDTH.
        r_o     = q_o ? (r_shift[WIDTH-1:0] - div_i) : r_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/applyconvolution_udiv_63ns_32ns_31_seq.sv
// ---------------------------------------------------------------------------
// applyconvolution_udiv_63ns_32ns_31_seq
//   Sequential unsigned restoring divider, one quotient bit per enabled
//   cycle. Result ready Q+1 enabled cycles after an accepted start
//   (1 cycle for divide-by-zero).
//   Ports:
//     clk, reset (sync, active-low), ce (clock enable for all state)
//     start        request, accepted only in IDLE with ce=1
//     din0 [N-1:0] dividend, din1 [D-1:0] divisor
//     busy         high in CALC and FIN
//     done         high in FIN
//     dout [Q-1:0] quotient, rem [D-1:0] remainder
//     dbz          last operation divided by zero
//     ovf          (only with APPLYCONV_UDIV_OVF_EN) quotient saturated
//   Build option: define APPLYCONV_UDIV_OVF_EN to add the overflow
//   pre-check and the ovf port.
// ---------------------------------------------------------------------------
module applyconvolution_udiv_63ns_32ns_31_seq
    import applyConvolution_udiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = UDIV_DIN0_W,
    parameter int din1_WIDTH = UDIV_DIN1_W,
    parameter int dout_WIDTH = UDIV_DOUT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dbz
`ifdef APPLYCONV_UDIV_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int N     = din0_WIDTH;
    localparam int D     = din1_WIDTH;
    localparam int Q     = dout_WIDTH;
    localparam int CNT_W = udiv_clog2(Q);

    if (ID < 0 || N != D + Q) begin : g_param_check
        $error("udiv: din0_WIDTH must equal din1_WIDTH + dout_WIDTH");
    end

    udiv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [D-1:0]     r_q,     r_d;
    logic [Q-1:0]     sh_q,    sh_d;   // dividend bits out the top, quotient bits in the bottom
    logic [D-1:0]     div_q,   div_d;
    logic [Q-1:0]     dout_q,  dout_d;
    logic [D-1:0]     rem_q,   rem_d;
    logic             dbz_q,   dbz_d;
`ifdef APPLYCONV_UDIV_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    logic [D-1:0]     step_r;
    logic             step_q;

    applyConvolution_udiv_step #(
        .WIDTH (D)
    ) u_step (
        .r_i   (r_q),
        .bit_i (sh_q[Q-1]),
        .div_i (div_q),
        .r_o   (step_r),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        sh_d    = sh_q;
        div_d   = div_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef APPLYCONV_UDIV_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    div_d = din1;
                    dbz_d = 1'b0;
                    cnt_d = '0;
`ifdef APPLYCONV_UDIV_OVF_EN
                    ovf_d = 1'b0;
`endif
                    if (din1 == '0) begin
                        state_d = ST_FIN;
                        dout_d  = '1;
                        rem_d   = din0[D-1:0];
                        dbz_d   = 1'b1;
                    end
`ifdef APPLYCONV_UDIV_OVF_EN
                    // Upper half >= divisor means the quotient needs more than Q bits.
                    else if (din0[N-1:Q] >= din1) begin
                        state_d = ST_FIN;
                        dout_d  = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_CALC;
                        r_d     = din0[N-1:Q];
                        sh_d    = din0[Q-1:0];
                    end
                end
            end
            ST_CALC: begin
                r_d   = step_r;
                sh_d  = {sh_q[Q-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(Q - 1)) begin
                    state_d = ST_FIN;
                    dout_d  = {sh_q[Q-2:0], step_q};
                    rem_d   = step_r;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            sh_q    <= '0;
            div_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef APPLYCONV_UDIV_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef APPLYCONV_UDIV_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign dout = dout_q;
    assign rem  = rem_q;
    assign dbz  = dbz_q;
`ifdef APPLYCONV_UDIV_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
